// File: rtl/register_file_param.sv
// register_file_param: parametrised 2R/1W register file with byte-enable writes, optional zero register, bypass and clear sweep
module register_file_param #(
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = 5,
    parameter int ZERO_REG0 = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    readReg1,
    input  logic [ADDR_W-1:0]    readReg2,
    input  logic [ADDR_W-1:0]    writeReg,
    input  logic                 writeEn,
    input  logic [WIDTH/8-1:0]   byteEn,
    input  logic [WIDTH-1:0]     writeData,
    input  logic                 clearReq,
    output logic                 busy,
    output logic [WIDTH-1:0]     outReg1,
    output logic [WIDTH-1:0]     outReg2
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB = WIDTH / 8;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [0:0] state;
    logic [ADDR_W-1:0] counter;
    logic [WIDTH-1:0] merged;
    logic wrOk;
    logic byp1;
    logic byp2;

    assign busy = state == SWEEP;
    assign wrOk = writeEn && state == IDLE && !(ZERO_REG0 != 0 && writeReg == '0);
    assign byp1 = BYPASS != 0 && wrOk && !reset && readReg1 == writeReg;
    assign byp2 = BYPASS != 0 && wrOk && !reset && readReg2 == writeReg;
    assign outReg1 = (ZERO_REG0 != 0 && readReg1 == '0) ? '0 : byp1 ? merged : mem[readReg1];
    assign outReg2 = (ZERO_REG0 != 0 && readReg2 == '0) ? '0 : byp2 ? merged : mem[readReg2];

    always_comb begin
        merged = mem[writeReg];
        for (int b = 0; b < NB; b++)
            if (byteEn[b]) merged[8*b +: 8] = writeData[8*b +: 8];
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            state <= IDLE;
            counter <= '0;
        end else if (state == SWEEP) begin
            mem[counter] <= '0;
            counter <= counter + 1'b1;
            if (&counter) state <= IDLE;
        end else begin
            if (wrOk) mem[writeReg] <= merged;
            if (clearReq) begin
                state <= SWEEP;
                counter <= '0;
            end
        end
    end
endmodule

// File: tb/tb_register_file_param.sv
// tb_register_file_param: directed self-checking bench for register_file_param (BYPASS=1 and BYPASS=0 builds)
module tb_register_file_param;
    logic CLK = 1'b0;
    logic reset, writeEn, clearReq;
    logic [4:0] readReg1, readReg2, writeReg;
    logic [3:0] byteEn;
    logic [31:0] writeData;
    logic busy, busyB;
    logic [31:0] outReg1, outReg2, outB1, outB2;
    int tests = 0;
    int failed = 0;
    int cnt;

    always #5 CLK = ~CLK;

    register_file_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG0(1), .BYPASS(1)) dut (
        .CLK(CLK), .reset(reset), .readReg1(readReg1), .readReg2(readReg2), .writeReg(writeReg),
        .writeEn(writeEn), .byteEn(byteEn), .writeData(writeData), .clearReq(clearReq),
        .busy(busy), .outReg1(outReg1), .outReg2(outReg2));

    register_file_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG0(1), .BYPASS(0)) dutB (
        .CLK(CLK), .reset(reset), .readReg1(readReg1), .readReg2(readReg2), .writeReg(writeReg),
        .writeEn(writeEn), .byteEn(byteEn), .writeData(writeData), .clearReq(clearReq),
        .busy(busyB), .outReg1(outB1), .outReg2(outB2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        writeReg = a; writeData = d; byteEn = be; writeEn = 1'b1;
        tick();
        writeEn = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] e1, input logic [31:0] e2);
        readReg1 = a1; readReg2 = a2;
        #1;
        check({tag, "_p1"}, outReg1, e1);
        check({tag, "_p2"}, outReg2, e2);
    endtask

    initial begin
        reset = 1'b1; writeEn = 1'b0; clearReq = 1'b0; readReg1 = '0; readReg2 = '0;
        writeReg = '0; byteEn = '0; writeData = '0;
        tick();
        reset = 1'b0;
        // 1: everything reads zero after reset
        for (int a = 0; a < 32; a++) rd($sformatf("rst_a%0d", a), 5'(a), 5'(31 - a), 32'h0, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        // 2: full-word writes
        wr(5'd1, 32'd15, 4'hF);
        wr(5'd2, 32'd30, 4'hF);
        wr(5'd31, 32'h4AD, 4'hF);
        rd("wr12", 5'd1, 5'd2, 32'd15, 32'd30);
        rd("wr31", 5'd31, 5'd1, 32'h4AD, 32'd15);
        // 3: byte merge, masked write, zero register
        wr(5'd5, 32'h11223344, 4'hF);
        wr(5'd5, 32'hAABBCCDD, 4'b0101);
        rd("bytemerge", 5'd5, 5'd2, 32'h11BB33DD, 32'd30);
        wr(5'd5, 32'hFFFFFFFF, 4'b0000);
        rd("be0", 5'd5, 5'd0, 32'h11BB33DD, 32'h0);
        wr(5'd0, 32'd7, 4'hF);
        rd("zero", 5'd0, 5'd0, 32'h0, 32'h0);
        // 4: bypass vs. no bypass
        writeReg = 5'd3; writeData = 32'h55; byteEn = 4'hF; writeEn = 1'b1;
        rd("byp", 5'd3, 5'd3, 32'h55, 32'h55);
        check("nobyp_pre", outB1, 32'h0);
        check("nobyp_pre2", outB2, 32'h0);
        tick();
        check("nobyp_post", outB1, 32'h55);
        writeReg = 5'd5; writeData = 32'h0000EE00; byteEn = 4'b0010;
        rd("byp_merge", 5'd5, 5'd3, 32'h11BBEEDD, 32'h55);
        check("nobyp_merge", outB1, 32'h11BB33DD);
        writeReg = 5'd0; writeData = 32'h9; byteEn = 4'hF;
        rd("byp_zero", 5'd0, 5'd0, 32'h0, 32'h0);
        writeEn = 1'b0;
        // 5: clear sweep
        for (int a = 1; a < 32; a++) wr(5'(a), 32'h01010101 * a, 4'hF);
        rd("fill", 5'd17, 5'd31, 32'h11111111, 32'h1F1F1F1F);
        clearReq = 1'b1;
        #1;
        check("busy_pre", {31'h0, busy}, 32'h0);
        tick();
        clearReq = 1'b0;
        check("busy_rise", {31'h0, busy}, 32'h1);
        cnt = 0;
        while (busy && cnt < 100) begin
            if (cnt == 5) begin
                writeReg = 5'd1; writeData = 32'hDEAD; byteEn = 4'hF; writeEn = 1'b1;
                rd("sweep_nobyp", 5'd1, 5'd20, 32'h0, 32'h14141414);
            end
            if (cnt == 6) writeEn = 1'b0;
            clearReq = cnt == 8;
            tick();
            cnt++;
        end
        clearReq = 1'b0;
        check("sweep_len", cnt, 32);
        check("busyB_done", {31'h0, busyB}, 32'h0);
        for (int a = 0; a < 32; a++) rd($sformatf("clr_a%0d", a), 5'(a), 5'(31 - a), 32'h0, 32'h0);
        // 6: simultaneous write+clear, then reset mid-sweep
        wr(5'd31, 32'hCAFE, 4'hF);
        writeReg = 5'd9; writeData = 32'h99; byteEn = 4'hF; writeEn = 1'b1; clearReq = 1'b1;
        tick();
        writeEn = 1'b0; clearReq = 1'b0;
        rd("wr_clr", 5'd9, 5'd31, 32'h99, 32'hCAFE);
        for (int i = 0; i < 10; i++) tick();
        rd("mid_sweep", 5'd9, 5'd31, 32'h0, 32'hCAFE);
        check("mid_busy", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'h0, busy}, 32'h0);
        rd("abort_rd", 5'd31, 5'd9, 32'h0, 32'h0);
        wr(5'd7, 32'h77, 4'hF);
        rd("post_wr", 5'd7, 5'd31, 32'h77, 32'h0);
        tick();
        check("post_busy", {31'h0, busy}, 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
